// File: rtl/rle_dec_pkg.sv
// Shared constants and types for the run-length block decoder.
//   COEF_W : signed coefficient width (matches the DCT output)
//   BLK_N  : coefficients per block
//   RUN_W  : zero-run field width
//   POS_W  : write-position width, wide enough to hold pos + run without wrap
package rle_dec_pkg;
  localparam int COEF_W = 19;
  localparam int BLK_N  = 8;
  localparam int RUN_W  = 3;
  localparam int POS_W  = 4;
  localparam int IDX_W  = 3;

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic [RUN_W-1:0]         run_t;
  typedef logic [POS_W-1:0]         pos_t;
  typedef logic [IDX_W-1:0]         idx_t;
endpackage

// File: rtl/rle_blk_buf.sv
// Block buffer: BLK_N x COEF_W register file.
//   clk, rst : clock, synchronous active-high reset (clears all slots)
//   clr      : synchronous clear of all slots
//   we, idx, wdata : single write port
//   rd       : parallel read-out, one entry per slot, straight from the registers
module rle_blk_buf
  import rle_dec_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clr,
  input  logic  we,
  input  idx_t  idx,
  input  coef_t wdata,
  output coef_t rd [BLK_N]
);

  generate
    for (genvar gi = 0; gi < BLK_N; gi++) begin : g_slot
      coef_t slot_reg;

      // Clear wins over write; the decoder never asserts both together.
      always_ff @(posedge clk) begin
        if (rst || clr) begin
          slot_reg <= '0;
        end else if (we && (idx == idx_t'(gi))) begin
          slot_reg <= wdata;
        end
      end

      assign rd[gi] = slot_reg;
    end
  endgenerate

endmodule

// File: rtl/rle_block_decoder.sv
// Run-length block decoder: turns (zero-run, coefficient) tokens into
// 8-coefficient blocks presented in parallel.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : token handshake; in_run, in_coef, in_eob token fields
//   out_valid/out_ready   : block handshake; out_coef0..7 block (0 = DC)
//   err_ovf               : sticky, a token's run overran the block
//   blk_cnt               : blocks delivered, wraps at 2^16
module rle_block_decoder
  import rle_dec_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [RUN_W-1:0]  in_run,
  input  logic [COEF_W-1:0] in_coef,
  input  logic              in_eob,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [COEF_W-1:0] out_coef0,
  output logic [COEF_W-1:0] out_coef1,
  output logic [COEF_W-1:0] out_coef2,
  output logic [COEF_W-1:0] out_coef3,
  output logic [COEF_W-1:0] out_coef4,
  output logic [COEF_W-1:0] out_coef5,
  output logic [COEF_W-1:0] out_coef6,
  output logic [COEF_W-1:0] out_coef7,
  output logic              err_ovf,
  output logic [15:0]       blk_cnt
);

  state_t      state_reg, state_next;
  pos_t        pos_reg;
  logic        err_ovf_reg;
  logic [15:0] blk_cnt_reg;

  pos_t  tgt;
  logic  accept, release_blk, buf_we, overrun;
  coef_t rd [BLK_N];

  // 4-bit sum cannot wrap: pos <= 7 while filling and run <= 7.
  assign tgt         = pos_reg + pos_t'(in_run);
  assign overrun     = (tgt > pos_t'(BLK_N - 1));
  assign accept      = in_valid && (state_reg == FILL);
  assign release_blk = out_ready && (state_reg == FULL);
  assign buf_we      = accept && !in_eob && !overrun;

  assign in_ready  = (state_reg == FILL);
  assign out_valid = (state_reg == FULL);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FILL: if (accept && (in_eob || tgt >= pos_t'(BLK_N - 1))) state_next = FULL;
      FULL: if (out_ready) state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= FILL;
      pos_reg     <= '0;
      err_ovf_reg <= 1'b0;
      blk_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (buf_we) begin
        pos_reg <= tgt + pos_t'(1);
      end else if (release_blk) begin
        pos_reg <= '0;
      end
      if (accept && !in_eob && overrun) begin
        err_ovf_reg <= 1'b1;
      end
      if (release_blk) begin
        blk_cnt_reg <= blk_cnt_reg + 16'd1;
      end
    end
  end

  // The release edge clears the buffer so skipped slots of the next block read 0.
  rle_blk_buf u_buf (
    .clk   (clk),
    .rst   (rst),
    .clr   (release_blk),
    .we    (buf_we),
    .idx   (tgt[IDX_W-1:0]),
    .wdata (coef_t'(in_coef)),
    .rd    (rd)
  );

  assign out_coef0 = rd[0];
  assign out_coef1 = rd[1];
  assign out_coef2 = rd[2];
  assign out_coef3 = rd[3];
  assign out_coef4 = rd[4];
  assign out_coef5 = rd[5];
  assign out_coef6 = rd[6];
  assign out_coef7 = rd[7];

  assign err_ovf = err_ovf_reg;
  assign blk_cnt = blk_cnt_reg;

endmodule
